// File: rtl/ans_freq_table.sv
// ans_freq_table: per-symbol count store answering PMF/CMF/ICMF queries
// for the rANS decoder; CMF/ICMF walk the table one symbol per cycle.
module ans_freq_table #(
  parameter int SYM_WIDTH = 4,
  parameter int CNT_WIDTH = 8,
  parameter int SYM_COUNT = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ena,
  input  logic [1:0]                     read_type,
  input  logic [CNT_WIDTH+SYM_WIDTH-1:0] read_query,
  output logic [CNT_WIDTH+SYM_WIDTH-1:0] read_result,
  output logic                           read_rdy,
  input  logic                           cfg_we,
  input  logic [SYM_WIDTH-1:0]           cfg_sym,
  input  logic [CNT_WIDTH-1:0]           cfg_cnt
);

  localparam int QW = CNT_WIDTH + SYM_WIDTH;

  localparam logic [1:0] RT_NONE = 2'd0;
  localparam logic [1:0] RT_PMF  = 2'd1;
  localparam logic [1:0] RT_CMF  = 2'd2;

  localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);
  localparam logic [QW-1:0]        LAST_Q   = QW'(SYM_COUNT - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [CNT_WIDTH-1:0] cnt [SYM_COUNT];

  state_t               state, state_n;
  logic [1:0]           cap_type, cap_type_n;
  logic [QW-1:0]        cap_query, cap_query_n;
  logic [SYM_WIDTH-1:0] idx, idx_n;
  logic [QW-1:0]        acc, acc_n;
  logic                 done, done_n;
  logic [QW-1:0]        result_n;

  logic                 match;
  logic [QW-1:0]        acc_next;
  logic [SYM_WIDTH-1:0] cmf_q;
  logic                 hit;

  assign match    = (read_type == cap_type) && (read_query == cap_query);
  assign read_rdy = done && match && (read_type != RT_NONE);
  assign acc_next = acc + QW'(cnt[idx]);
  assign cmf_q    = (cap_query > LAST_Q) ? LAST_SYM
                                         : cap_query[SYM_WIDTH-1:0];

  always_comb begin
    hit = 1'b0;
    unique case (1'b1)
      (cap_type == RT_CMF): hit = (idx == cmf_q);
      default:              hit = (cap_query < acc_next) ||
                                  (idx == LAST_SYM);
    endcase
  end

  always_comb begin
    state_n     = state;
    cap_type_n  = cap_type;
    cap_query_n = cap_query;
    idx_n       = idx;
    acc_n       = acc;
    done_n      = done;
    result_n    = read_result;
    // a count write invalidates everything and forces a recapture
    if (cfg_we) begin
      done_n  = 1'b0;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (done) begin
            if (!match) done_n = 1'b0;
          end else if (read_type != RT_NONE) begin
            cap_type_n  = read_type;
            cap_query_n = read_query;
            acc_n       = '0;
            idx_n       = '0;
            if (read_type == RT_PMF) begin
              result_n = QW'(cnt[read_query[SYM_WIDTH-1:0]]);
              done_n   = 1'b1;
            end else begin
              state_n = SCAN;
            end
          end
        end
        SCAN: begin
          if (!match) begin
            state_n = IDLE;
          end else if (hit) begin
            result_n = (cap_type == RT_CMF) ? acc_next
                                            : QW'(idx);
            done_n   = 1'b1;
            state_n  = IDLE;
          end else begin
            acc_n = acc_next;
            idx_n = idx + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cap_type    <= RT_NONE;
      cap_query   <= '0;
      idx         <= '0;
      acc         <= '0;
      done        <= 1'b0;
      read_result <= '0;
      for (int i = 0; i < SYM_COUNT; i++)
        cnt[i] <= CNT_WIDTH'(1);
    end else if (ena) begin
      state       <= state_n;
      cap_type    <= cap_type_n;
      cap_query   <= cap_query_n;
      idx         <= idx_n;
      acc         <= acc_n;
      done        <= done_n;
      read_result <= result_n;
      if (cfg_we) cnt[cfg_sym] <= cfg_cnt;
    end
  end

endmodule

// File: tb/tb_ans_freq_table.sv
// tb_ans_freq_table: directed + random queries against an array model
// of the count table, checking results and latencies.
module tb_ans_freq_table;

  localparam int SW = 4;
  localparam int CW = 8;
  localparam int SC = 16;
  localparam int QW = SW + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [1:0]    read_type = 2'd0;
  logic [QW-1:0] read_query = '0;
  logic [QW-1:0] read_result;
  logic          read_rdy;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_sym = '0;
  logic [CW-1:0] cfg_cnt = '0;

  int vectors = 0;
  int miscompares = 0;
  int m [SC];

  always #5 clk = ~clk;

  ans_freq_table #(.SYM_WIDTH(SW), .CNT_WIDTH(CW), .SYM_COUNT(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .read_type(read_type), .read_query(read_query),
    .read_result(read_result), .read_rdy(read_rdy),
    .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_cnt(cfg_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_total();
    int t = 0;
    for (int i = 0; i < SC; i++) t += m[i];
    return t;
  endfunction

  function automatic int model_cmf(input int q);
    int s = (q > SC - 1) ? SC - 1 : q;
    int t = 0;
    for (int i = 0; i <= s; i++) t += m[i];
    return t;
  endfunction

  function automatic int model_icmf(input int v);
    int t = 0;
    for (int i = 0; i < SC; i++) begin
      t += m[i];
      if (v < t) return i;
    end
    return SC - 1;
  endfunction

  function automatic int model_res(input int t, input int q);
    if (t == 1) return m[q % SC];
    if (t == 2) return model_cmf(q);
    return model_icmf(q);
  endfunction

  function automatic int model_lat(input int t, input int q);
    if (t == 1) return 1;
    if (t == 2) return ((q > SC - 1) ? SC - 1 : q) + 2;
    return model_icmf(q) + 2;
  endfunction

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (read_rdy === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic start_req(input string tag, input int t, input int q);
    @(posedge clk); #1;
    read_type = 2'd0;
    @(negedge clk);
    check({tag, "_none_drop"}, 32'(read_rdy), 0);
    @(posedge clk); #1;
    read_type  = 2'(t);
    read_query = QW'(q);
  endtask

  task automatic finish_req(input string tag, input int exp_res,
                            input int exp_lat);
    int lat;
    wait_rdy(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, 32'(read_result), 32'(exp_res));
    @(negedge clk);
    check({tag, "_hold"}, 32'(read_rdy), 1);
  endtask

  task automatic query(input string tag, input int t, input int q);
    start_req(tag, t, q);
    finish_req(tag, model_res(t, q), model_lat(t, q));
  endtask

  task automatic cfg_write(input int s, input int c);
    @(posedge clk); #1;
    read_type = 2'd0;
    cfg_we = 1'b1; cfg_sym = SW'(s); cfg_cnt = CW'(c);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m[s] = c;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < SC; i++) m[i] = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", 32'(read_rdy), 0);
    check("reset_res", 32'(read_result), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    query("cmf15_uniform", 2, 15);
    cfg_write(0, 3); cfg_write(1, 5); cfg_write(2, 0); cfg_write(3, 8);
    query("pmf1", 1, 1);
    query("cmf0", 2, 0);
    query("cmf3", 2, 3);
    query("icmf2", 3, 2);
    query("icmf3", 3, 3);
    query("icmf7", 3, 7);
    query("icmf8", 3, 8);
    query("icmf_over", 3, model_total() + 5);
    query("cmf_ones", 2, (1 << QW) - 1);
    query("pmf3", 1, 3);
    query("pmf_hi", 1, 12'h5A3);

    // query changes mid ICMF scan
    start_req("chg", 3, 8);
    repeat (2) begin
      @(negedge clk);
      check("chg_early", 32'(read_rdy), 0);
    end
    @(posedge clk); #1;
    read_query = QW'(2);
    finish_req("chg", model_icmf(2), model_icmf(2) + 3);

    // count write mid CMF scan
    start_req("cfgmid", 2, 3);
    repeat (2) begin
      @(negedge clk);
      check("cfgmid_early", 32'(read_rdy), 0);
    end
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_sym = SW'(1); cfg_cnt = CW'(1);
    @(negedge clk);
    check("cfgmid_pulse", 32'(read_rdy), 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m[1] = 1;
    finish_req("cfgmid", model_cmf(3), 5);

    // ena low freezes the scan
    start_req("ena", 2, 5);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("ena_frozen", 32'(read_rdy), 0);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    finish_req("ena", model_cmf(5), 4);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int t, q;
      if ($urandom_range(0, 3) == 0)
        cfg_write($urandom_range(0, SC - 1), $urandom_range(0, 255));
      t = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) q = $urandom_range(0, 4095);
      else if (t == 3) q = $urandom_range(0, model_total() + 3);
      else q = $urandom_range(0, SC - 1);
      query("rand", t, q);
    end

    // reset during a CMF scan, request held through it
    start_req("rst", 2, 15);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(read_rdy), 0);
    check("rst_res", 32'(read_result), 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < SC; i++) m[i] = 1;
    wait_rdy(lat);
    check("rst_cmf_lat", 32'(lat), 17);
    check("rst_cmf_res", 32'(read_result), 16);
    query("rst_pmf3", 1, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
